// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/retire controller for the 2-stage 33x33 Booth/Wallace
// multiplier in the EXE stage. Extends operands, tracks the op held in the
// multiplier's internal pipeline register (S1), selects the lo/hi product
// word in S2 and parks results in a small in-order FIFO so the non-stallable
// multiplier never loses data when the MEM stage back-pressures.
//
// Optional build macro: MUL_PERF_CNT_EN adds perf_mul_cnt / perf_stall_cnt.
//
// Handshake (both sides, strict valid/ready): a transfer happens on a rising
// edge exactly when valid & ready are both high in that cycle. in_ready is a
// credit check (S1 + buffered results - this cycle's pop < BUF_DEPTH) so every
// accepted op has a guaranteed buffer slot two cycles later; it depends
// combinationally on out_ready, never on in_valid. out_* never depend on in_*.
module mul_issue_ctrl #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter int BUF_DEPTH = 2   // legal 2..4
) (
  input  logic                mul_clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [XLEN-1:0]     in_src1,
  input  logic [XLEN-1:0]     in_src2,
  input  logic [TAG_W-1:0]    in_tag,
  output logic [XLEN:0]       mul_a,
  output logic [XLEN:0]       mul_b,
  input  logic [2*XLEN+1:0]   mul_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic [TAG_W-1:0]    out_tag
`ifdef MUL_PERF_CNT_EN
  ,
  output logic [31:0]         perf_mul_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  localparam logic [1:0] OP_MULH_W  = 2'b01;
  localparam logic [1:0] OP_MULH_WU = 2'b10;

  // S1: op currently inside the multiplier's pipeline register
  logic               r_s1_valid;
  logic [1:0]         r_s1_op;
  logic [TAG_W-1:0]   r_s1_tag;

  // Result FIFO
  logic [XLEN-1:0]    r_buf_data [BUF_DEPTH];
  logic [TAG_W-1:0]   r_buf_tag  [BUF_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_ext_sign;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [OCC_W-1:0]   w_occ;
  logic               w_sel_hi;
  logic [XLEN-1:0]    w_sel;
  logic               w_unused_prod_top;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Only MULH_WU treats operands as unsigned; MUL_W, MULH_W and the reserved
  // encoding all sign-extend. The multiplier has no enable, so operands are
  // driven every cycle and only validity is tracked here.
  assign w_ext_sign = (in_op != OP_MULH_WU);
  assign mul_a      = {w_ext_sign & in_src1[XLEN-1], in_src1};
  assign mul_b      = {w_ext_sign & in_src2[XLEN-1], in_src2};

  assign out_valid  = (r_count != '0);
  assign out_result = r_buf_data[r_rd_ptr];
  assign out_tag    = r_buf_tag[r_rd_ptr];

  assign w_pop      = out_valid & out_ready;
  assign w_push     = r_s1_valid;
  assign w_occ      = OCC_W'(r_count) + OCC_W'(r_s1_valid) - OCC_W'(w_pop);
  assign in_ready   = resetn & ~flush & (w_occ < OCC_W'(BUF_DEPTH));
  assign w_accept   = in_valid & in_ready;

  // Hi word for both MULH flavours; lo word for MUL_W and the reserved op.
  assign w_sel_hi   = (r_s1_op == OP_MULH_W) | (r_s1_op == OP_MULH_WU);
  assign w_sel      = w_sel_hi ? mul_result[2*XLEN-1:XLEN] : mul_result[XLEN-1:0];

  // The two extra product bits from the 33x33 array are never selected.
  assign w_unused_prod_top = ^mul_result[2*XLEN+1:2*XLEN];

  // S1 tracking register: follows the op into the multiplier pipeline.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_tag   <= '0;
    end else begin
      // in_ready is already low during flush, so accept implies no flush.
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_op  <= in_op;
        r_s1_tag <= in_tag;
      end
    end
  end

  // Result FIFO: S2 pushes the selected word, consumer pops from the head.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_data[i] <= '0;
        r_buf_tag[i]  <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      // Flush wins over any same-cycle push or pop.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= w_sel;
        r_buf_tag[r_wr_ptr]  <= r_s1_tag;
        r_wr_ptr             <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

`ifdef MUL_PERF_CNT_EN
  logic [31:0] r_perf_mul_cnt;
  logic [31:0] r_perf_stall_cnt;

  assign perf_mul_cnt   = r_perf_mul_cnt;
  assign perf_stall_cnt = r_perf_stall_cnt;

  // Perf counters: accepted ops and back-pressure stalls; flush does not clear them.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      r_perf_mul_cnt   <= '0;
      r_perf_stall_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_perf_mul_cnt <= r_perf_mul_cnt + 32'd1;
      end
      if (in_valid & ~in_ready & ~flush) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: self-checking bench for mul_issue_ctrl. A behavioural
// 33x33 multiplier with one cycle of latency sits behind the DUT; expected
// results come from a 64-bit arithmetic reference keyed on the op type.
module tb_mul_issue_ctrl;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int PW    = TAG_W + XLEN;

  logic              mul_clk = 1'b0;
  logic              resetn  = 1'b0;
  logic              flush   = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_op   = '0;
  logic [XLEN-1:0]   in_src1 = '0;
  logic [XLEN-1:0]   in_src2 = '0;
  logic [TAG_W-1:0]  in_tag  = '0;
  logic [XLEN:0]     mul_a;
  logic [XLEN:0]     mul_b;
  logic [2*XLEN+1:0] mul_result = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   out_result;
  logic [TAG_W-1:0]  out_tag;
`ifdef MUL_PERF_CNT_EN
  logic [31:0]       perf_mul_cnt;
  logic [31:0]       perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // scoreboard
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] pair_exp_q[$];
  logic [PW-1:0] pair_got_q[$];
  int            pop_cyc_q[$];
  logic [PW-1:0] mon_e;
`ifdef MUL_PERF_CNT_EN
  logic [31:0]   m_mul_cnt;
  logic [31:0]   m_stall_cnt;
`endif

  mul_issue_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .BUF_DEPTH(2)) dut (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
`ifdef MUL_PERF_CNT_EN
    ,
    .perf_mul_cnt   (perf_mul_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // ---------------- clock / reset / multiplier model ----------------
  always #5 mul_clk = ~mul_clk;

  always @(posedge mul_clk) cyc <= cyc + 1;

  // Multiplier: signed 33x33 product, registered once (result one cycle later).
  always @(posedge mul_clk) begin
    logic signed [2*XLEN+1:0] pa, pb;
    pa = {{(XLEN+1){mul_a[XLEN]}}, mul_a};
    pb = {{(XLEN+1){mul_b[XLEN]}}, mul_b};
    mul_result <= pa * pb;
  end

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    sp = sa * sb;
    up = {32'b0, a} * {32'b0, b};
    case (op)
      2'b01:   return sp[63:32];
      2'b10:   return up[63:32];
      default: return up[31:0];
    endcase
  endfunction

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: records accepts into the expected queue, pairs each pop with
  // the oldest expected entry. Flush/reset kill everything still in flight.
  always @(negedge mul_clk) begin
    if (!resetn || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) mon_e = exp_q.pop_front();
        else                  mon_e = 'x;
        pair_exp_q.push_back(mon_e);
        pair_got_q.push_back({out_tag, out_result});
        pop_cyc_q.push_back(cyc);
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_tag, ref_mul(in_op, in_src1, in_src2)});
    end
`ifdef MUL_PERF_CNT_EN
    if (!resetn) begin
      m_mul_cnt   = '0;
      m_stall_cnt = '0;
    end else begin
      if (in_valid && in_ready)            m_mul_cnt   = m_mul_cnt + 1;
      if (in_valid && !in_ready && !flush) m_stall_cnt = m_stall_cnt + 1;
    end
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic clear_sb();
    pair_exp_q.delete();
    pair_got_q.delete();
    pop_cyc_q.delete();
  endtask

  // Stops issuing, lets everything drain with out_ready high.
  task automatic drain(output bit timed_out);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() > 0 || out_valid) && n < 50) begin
      @(posedge mul_clk); #1;
      n++;
    end
    repeat (2) @(posedge mul_clk);
    #1;
    timed_out = (n >= 50);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn   = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge mul_clk);
    @(negedge mul_clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_result !== '0) $display("FAIL reset_out_result: got %h want 0", out_result); else n_pass++;
    n_checks++; if (out_tag !== '0) $display("FAIL reset_out_tag: got %h want 0", out_tag); else n_pass++;
    @(posedge mul_clk); #1;
    resetn   = 1'b1;
    in_valid = 1'b0;
    @(negedge mul_clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid: got %b want 0", out_valid); else n_pass++;
    @(posedge mul_clk); #1;
  endtask

  // Single ops with hand-computed products: latency, word select, extension.
  task automatic test_latency();
    logic [1:0]       t_op  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [XLEN-1:0]  t_a   [4] = '{32'h3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7};
    logic [XLEN-1:0]  t_b   [4] = '{32'hFFFF_FFFB, 32'h8000_0000, 32'hFFFF_FFFF, 32'h6};
    logic [XLEN-1:0]  t_exp [4] = '{32'hFFFF_FFF1, 32'h4000_0000, 32'hFFFF_FFFE, 32'h2A};
    logic [TAG_W-1:0] t_tag [4] = '{5'h0A, 5'h15, 5'h1F, 5'h03};
    logic [XLEN:0]    ea, eb;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_op    = t_op[i];
      in_src1  = t_a[i];
      in_src2  = t_b[i];
      in_tag   = t_tag[i];
      ea = (t_op[i] == 2'b10) ? {1'b0, t_a[i]} : {t_a[i][31], t_a[i]};
      eb = (t_op[i] == 2'b10) ? {1'b0, t_b[i]} : {t_b[i][31], t_b[i]};
      @(negedge mul_clk);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL lat_accept[%0d]: in_ready %b want 1", i, in_ready); else n_pass++;
      n_checks++; if (mul_a !== ea) $display("FAIL lat_mul_a[%0d]: got %h want %h", i, mul_a, ea); else n_pass++;
      n_checks++; if (mul_b !== eb) $display("FAIL lat_mul_b[%0d]: got %h want %h", i, mul_b, eb); else n_pass++;
      @(posedge mul_clk); #1;
      in_valid = 1'b0;
      @(negedge mul_clk);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL lat_early[%0d]: out_valid %b want 0 at T+1", i, out_valid); else n_pass++;
      @(posedge mul_clk); #1;
      @(negedge mul_clk);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL lat_valid[%0d]: out_valid %b want 1 at T+2", i, out_valid); else n_pass++;
      n_checks++; if (out_result !== t_exp[i]) $display("FAIL lat_result[%0d]: got %h want %h", i, out_result, t_exp[i]); else n_pass++;
      n_checks++; if (out_tag !== t_tag[i]) $display("FAIL lat_tag[%0d]: got %h want %h", i, out_tag, t_tag[i]); else n_pass++;
      @(posedge mul_clk); #1;
    end
  endtask

  // 8 back-to-back mixed ops at full throughput.
  task automatic test_back_to_back();
    bit to;
    logic [PW-1:0] g, e;
    clear_sb();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_op    = 2'($urandom_range(0, 3));
      in_src1  = pick_operand();
      in_src2  = pick_operand();
      in_tag   = TAG_W'(i + 8);
      @(negedge mul_clk);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
      @(posedge mul_clk); #1;
    end
    drain(to);
    n_checks++; if (to) $display("FAIL b2b_drain: timed out, got 1 want 0"); else n_pass++;
    n_checks++; if (pair_got_q.size() != 8) $display("FAIL b2b_count: got %0d want 8", pair_got_q.size()); else n_pass++;
    for (int i = 1; i < pop_cyc_q.size(); i++) begin
      n_checks++;
      if (pop_cyc_q[i] != pop_cyc_q[0] + i) $display("FAIL b2b_consecutive[%0d]: cycle %0d want %0d", i, pop_cyc_q[i], pop_cyc_q[0] + i);
      else n_pass++;
    end
    while (pair_got_q.size() > 0) begin
      g = pair_got_q.pop_front();
      e = pair_exp_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL b2b_result: got %h want %h", g, e); else n_pass++;
    end
  endtask

  // Consumer stalled: exactly two accepted, head stable, resume on first pop.
  task automatic test_backpressure();
    bit to;
    int n_acc = 0;
    logic [PW-1:0] head_a, head_want, g, e;
    clear_sb();
    out_ready = 1'b0;
    head_a    = '0;
    head_want = '0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_op    = 2'($urandom_range(0, 3));
      in_src1  = pick_operand();
      in_src2  = pick_operand();
      in_tag   = TAG_W'($urandom_range(0, 31));
      @(negedge mul_clk);
      if (in_ready) n_acc++;
      if (i == 3) head_a = {out_tag, out_result};
      if (i == 5) head_want = exp_q[0];
      @(posedge mul_clk); #1;
    end
    @(negedge mul_clk);
    n_checks++; if (n_acc != 2) $display("FAIL bp_accepted: got %0d want 2", n_acc); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if ({out_tag, out_result} !== head_a) $display("FAIL bp_head_stable: got %h want %h", {out_tag, out_result}, head_a); else n_pass++;
    n_checks++; if ({out_tag, out_result} !== head_want) $display("FAIL bp_head_value: got %h want %h", {out_tag, out_result}, head_want); else n_pass++;
    @(posedge mul_clk); #1;
    out_ready = 1'b1;
    in_tag    = 5'h11;
    @(negedge mul_clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_resume: in_ready %b want 1 on first pop", in_ready); else n_pass++;
    @(posedge mul_clk); #1;
    drain(to);
    n_checks++; if (to) $display("FAIL bp_drain: timed out, got 1 want 0"); else n_pass++;
    n_checks++; if (pair_got_q.size() != 3) $display("FAIL bp_count: got %0d want 3", pair_got_q.size()); else n_pass++;
    while (pair_got_q.size() > 0) begin
      g = pair_got_q.pop_front();
      e = pair_exp_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL bp_result: got %h want %h", g, e); else n_pass++;
    end
  endtask

  // Flush with one op in S1 and one buffered; nothing survives, next op ok.
  task automatic test_flush();
    bit to;
    logic [PW-1:0] g, e;
    clear_sb();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_op    = 2'($urandom_range(0, 3));
      in_src1  = pick_operand();
      in_src2  = pick_operand();
      in_tag   = TAG_W'(i + 1);
      @(posedge mul_clk); #1;
    end
    flush   = 1'b1;
    in_tag  = 5'h1E;
    @(negedge mul_clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready); else n_pass++;
    @(posedge mul_clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge mul_clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready_after: got %b want 1", in_ready); else n_pass++;
    @(posedge mul_clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 2'b01;
    in_src1   = 32'hFFFF_FFFF;
    in_src2   = 32'h0000_0002;
    in_tag    = 5'h07;
    @(posedge mul_clk); #1;
    drain(to);
    n_checks++; if (to) $display("FAIL flush_drain: timed out, got 1 want 0"); else n_pass++;
    n_checks++; if (pair_got_q.size() != 1) $display("FAIL flush_count: got %0d want 1", pair_got_q.size()); else n_pass++;
    while (pair_got_q.size() > 0) begin
      g = pair_got_q.pop_front();
      e = pair_exp_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL flush_result: got %h want %h", g, e); else n_pass++;
    end
  endtask

  // One-cycle reset with ops in flight.
  task automatic test_reset_mid();
    bit to;
    logic [PW-1:0] g, e;
    clear_sb();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = 2'($urandom_range(0, 3));
      in_src1  = pick_operand();
      in_src2  = pick_operand();
      in_tag   = TAG_W'(i + 20);
      @(posedge mul_clk); #1;
    end
    in_valid = 1'b0;
    resetn   = 1'b0;
    @(posedge mul_clk); #1;
    resetn = 1'b1;
    @(negedge mul_clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_result !== '0) $display("FAIL rst_mid_out_result: got %h want 0", out_result); else n_pass++;
    n_checks++; if (out_tag !== '0) $display("FAIL rst_mid_out_tag: got %h want 0", out_tag); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); else n_pass++;
`ifdef MUL_PERF_CNT_EN
    n_checks++; if (perf_mul_cnt !== 32'd0) $display("FAIL rst_mid_perf_mul: got %0d want 0", perf_mul_cnt); else n_pass++;
    n_checks++; if (perf_stall_cnt !== 32'd0) $display("FAIL rst_mid_perf_stall: got %0d want 0", perf_stall_cnt); else n_pass++;
`endif
    @(posedge mul_clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 2'b10;
    in_src1   = 32'h1234_5678;
    in_src2   = 32'h9ABC_DEF0;
    in_tag    = 5'h19;
    @(posedge mul_clk); #1;
    drain(to);
    n_checks++; if (to) $display("FAIL rst_mid_drain: timed out, got 1 want 0"); else n_pass++;
    n_checks++; if (pair_got_q.size() != 1) $display("FAIL rst_mid_count: got %0d want 1", pair_got_q.size()); else n_pass++;
    while (pair_got_q.size() > 0) begin
      g = pair_got_q.pop_front();
      e = pair_exp_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL rst_mid_result: got %h want %h", g, e); else n_pass++;
    end
  endtask

  // Randomized traffic, back-pressure and occasional flushes.
  task automatic test_random();
    bit to;
    bit prev_flush = 1'b0;
    logic [PW-1:0] g, e;
    clear_sb();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_src1   = pick_operand();
      in_src2   = pick_operand();
      in_tag    = TAG_W'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      @(negedge mul_clk);
      if (flush) begin
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rnd_flush_in_ready[%0d]: got %b want 0", i, in_ready); else n_pass++;
      end
      if (prev_flush) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rnd_post_flush_valid[%0d]: got %b want 0", i, out_valid); else n_pass++;
      end
      prev_flush = flush;
      @(posedge mul_clk); #1;
    end
    flush = 1'b0;
    drain(to);
    n_checks++; if (to) $display("FAIL rnd_drain: timed out, got 1 want 0"); else n_pass++;
    n_checks++; if (pair_got_q.size() < 50) $display("FAIL rnd_volume: got %0d pops want >= 50", pair_got_q.size()); else n_pass++;
    while (pair_got_q.size() > 0) begin
      g = pair_got_q.pop_front();
      e = pair_exp_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL rnd_result: got %h want %h", g, e); else n_pass++;
    end
  endtask

`ifdef MUL_PERF_CNT_EN
  task automatic test_perf();
    // Idle cycle: neither counter can move, so the model is exact here.
    in_valid = 1'b0;
    @(negedge mul_clk);
    n_checks++; if (perf_mul_cnt !== m_mul_cnt) $display("FAIL perf_mul: got %0d want %0d", perf_mul_cnt, m_mul_cnt); else n_pass++;
    n_checks++; if (perf_stall_cnt !== m_stall_cnt) $display("FAIL perf_stall: got %0d want %0d", perf_stall_cnt, m_stall_cnt); else n_pass++;
    @(posedge mul_clk); #1;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef MUL_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
